// File: rtl/timer_counter_if.sv
// CPU-bridge register port of one timer_counter: address/write strobe/data in,
// read data and interrupt request out.
interface timer_counter_if;
   localparam int unsigned BUS_W = 32;

   logic [BUS_W-1:0] Addr;
   logic             WE;
   logic [BUS_W-1:0] Din;
   logic [BUS_W-1:0] Dout;
   logic             IRQ;

   modport master (output Addr, output WE, output Din, input Dout, input IRQ);
   modport slave  (input Addr, input WE, input Din, output Dout, output IRQ);
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped down-counter timer with CTRL/PRESET/COUNT registers,
// one-shot and auto-reload modes, and a maskable interrupt.
module timer_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   timer_counter_if.slave  bus
);
   localparam int unsigned BUS_W  = 32;
   localparam int unsigned MODE_W = 2;

   localparam logic [1:0] A_CTRL   = 2'b00;
   localparam logic [1:0] A_PRESET = 2'b01;
   localparam logic [1:0] A_COUNT  = 2'b10;
   localparam logic [MODE_W-1:0] MODE_RELOAD = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CNT,
      ST_INT
   } state_t;

   state_t              state;
   logic                ctrl_en;
   logic [MODE_W-1:0]   ctrl_mode;
   logic                ctrl_im;
   logic [CNT_W-1:0]    preset;
   logic [CNT_W-1:0]    count;
   logic                irq_pend;

   logic                wr_ctrl_c;
   logic                wr_preset_c;
   logic                load_entry_c;
   logic                irq_set_c;
   logic                irq_clr_c;
   logic                unused_addr;

   assign unused_addr = ^{bus.Addr[BUS_W-1:4], bus.Addr[1:0]};

   assign wr_ctrl_c    = bus.WE && (bus.Addr[3:2] == A_CTRL);
   assign wr_preset_c  = bus.WE && (bus.Addr[3:2] == A_PRESET);
   // Entering LOAD from IDLE or from an auto-reload INT drops the pending flag,
   // so a reload interrupt is a single-cycle pulse.
   assign load_entry_c = ((state == ST_IDLE) && ctrl_en) ||
                         ((state == ST_INT) && (ctrl_mode == MODE_RELOAD));
   assign irq_set_c    = (state == ST_CNT) && ctrl_en && (count <= CNT_W'(1));
   assign irq_clr_c    = wr_ctrl_c || wr_preset_c || load_entry_c;

   // Control/counter sequencer; CPU writes to CTRL are applied last so they
   // override the one-shot EN clear in the same cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         ctrl_en   <= 1'b0;
         ctrl_mode <= '0;
         ctrl_im   <= 1'b0;
         preset    <= '0;
         count     <= '0;
         irq_pend  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (ctrl_en) state <= ST_LOAD;
            end
            ST_LOAD: begin
               count <= preset;
               state <= ST_CNT;
            end
            ST_CNT: begin
               if (!ctrl_en) begin
                  state <= ST_IDLE;
               end else if (count > CNT_W'(1)) begin
                  count <= count - CNT_W'(1);
               end else begin
                  count <= '0;
                  state <= ST_INT;
               end
            end
            ST_INT: begin
               if (ctrl_mode == MODE_RELOAD) begin
                  state <= ST_LOAD;
               end else begin
                  ctrl_en <= 1'b0;
                  state   <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase

         if (wr_ctrl_c) begin
            ctrl_en   <= bus.Din[0];
            ctrl_mode <= bus.Din[2:1];
            ctrl_im   <= bus.Din[3];
         end
         if (wr_preset_c) preset <= CNT_W'(bus.Din);

         // A set on the final count beats any clear in the same cycle.
         if (irq_set_c)      irq_pend <= 1'b1;
         else if (irq_clr_c) irq_pend <= 1'b0;
      end
   end

   // Zero-latency read mux.
   always_comb begin
      bus.Dout = '0;
      case (bus.Addr[3:2])
         A_CTRL:   bus.Dout = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
         A_PRESET: bus.Dout = BUS_W'(preset);
         A_COUNT:  bus.Dout = BUS_W'(count);
         default:  bus.Dout = '0;
      endcase
   end

   assign bus.IRQ = irq_pend & ctrl_im;
endmodule
